// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the request arbiter slice.
//   ARB_FIXED / ARB_RR : arbitration policy encodings (MODE parameter)
//   ST_IDLE / ST_BUSY  : arbiter state encodings
//   clog2 / max1       : elaboration-time width helpers
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Clamp a width to at least one bit.
    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational search for the first eligible requester, scanning upward from
// a start index with wrap-around. Fixed priority is the special case start=0.
//   req   : request vector
//   start : index at which the search begins (must be < NREQ)
//   excl  : requesters removed from the search (pre-empted holder)
//   found : at least one eligible requester exists
//   idx   : index of the chosen requester (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = max1(clog2(NREQ))
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    input  logic [NREQ-1:0] excl,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0]   cand_s;
    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;

    // Rotate the candidate vector so the start index lands on bit 0.
    always_comb begin
        cand_s = req & ~excl;
        dbl_s  = {cand_s, cand_s} >> start;
        rot_s  = dbl_s[NREQ-1:0];
    end

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        int off;
        int sum;
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot_s[j]) begin
                found = 1'b1;
                off   = j;
            end else begin
                found = found;
            end
        end
        sum = int'(start) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        idx = found ? IW'(sum) : {IW{1'b0}};
    end

endmodule

// File: rtl/arbiter_rr.sv
// -----------------------------------------------------------------------------
// arbiter_rr
// Packet-locking arbiter with fixed-priority or round-robin selection and an
// optional hold limit that pre-empts a long-running holder when others wait.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-low reset
//   req       : level-held request vector
//   gnt       : registered one-hot grant (zero when idle)
//   gnt_id    : registered index of the granted requester (0 when idle)
//   gnt_valid : registered OR of gnt
// -----------------------------------------------------------------------------
module arbiter_rr
    import arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    output logic [NREQ-1:0]              gnt,
    output logic [max1(clog2(NREQ))-1:0] gnt_id,
    output logic                         gnt_valid
);

    localparam int IW = max1(clog2(NREQ));
    localparam int HW = max1(clog2(MAX_HOLD + 1));

    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b0}};
    localparam logic          HOLD_EN   = (MAX_HOLD > 0);

    logic [0:0]      state_r;
    logic [NREQ-1:0] gnt_r;
    logic [IW-1:0]   gnt_id_r;
    logic            gnt_valid_r;
    logic [IW-1:0]   ptr_r;
    logic [HW-1:0]   hold_cnt_r;

    logic [0:0]      state_nxt_s;
    logic [NREQ-1:0] gnt_nxt_s;
    logic [IW-1:0]   gnt_id_nxt_s;
    logic            gnt_valid_nxt_s;
    logic [IW-1:0]   ptr_nxt_s;
    logic [HW-1:0]   hold_cnt_nxt_s;

    logic            holder_req_s;
    logic            others_s;
    logic            preempt_s;
    logic            rearb_s;
    logic [IW-1:0]   start_s;
    logic [NREQ-1:0] excl_s;
    logic            pick_found_s;
    logic [IW-1:0]   pick_idx_s;

    // Decide whether this edge keeps the current holder or re-arbitrates.
    always_comb begin
        holder_req_s = |(req & gnt_r);
        others_s     = |(req & ~gnt_r);
        // Hold limit reached with someone else waiting: kick the holder out.
        preempt_s    = HOLD_EN && (state_r == ST_BUSY) && holder_req_s &&
                       (hold_cnt_r == HOLD_LAST) && others_s;
        rearb_s      = (state_r == ST_IDLE) || !holder_req_s || preempt_s;
        start_s      = (MODE == ARB_RR) ? ptr_r : {IW{1'b0}};
        excl_s       = preempt_s ? gnt_r : {NREQ{1'b0}};
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .start (start_s),
        .excl  (excl_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state values for the grant registers, pointer and hold counter.
    always_comb begin
        state_nxt_s     = state_r;
        gnt_nxt_s       = gnt_r;
        gnt_id_nxt_s    = gnt_id_r;
        gnt_valid_nxt_s = gnt_valid_r;
        ptr_nxt_s       = ptr_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        if (rearb_s) begin
            if (pick_found_s) begin
                state_nxt_s     = ST_BUSY;
                gnt_nxt_s       = NREQ'(1'b1) << pick_idx_s;
                gnt_id_nxt_s    = pick_idx_s;
                gnt_valid_nxt_s = 1'b1;
                ptr_nxt_s       = (pick_idx_s == LAST_IDX) ? {IW{1'b0}} : pick_idx_s + IW'(1'b1);
                hold_cnt_nxt_s  = {HW{1'b0}};
            end else begin
                state_nxt_s     = ST_IDLE;
                gnt_nxt_s       = {NREQ{1'b0}};
                gnt_id_nxt_s    = {IW{1'b0}};
                gnt_valid_nxt_s = 1'b0;
                hold_cnt_nxt_s  = {HW{1'b0}};
            end
        end else begin
            // Packet lock: grant unchanged, count held cycles up to the limit.
            if (hold_cnt_r == HOLD_SAT) begin
                hold_cnt_nxt_s = hold_cnt_r;
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + HW'(1'b1);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= {NREQ{1'b0}};
            gnt_id_r    <= {IW{1'b0}};
            gnt_valid_r <= 1'b0;
            ptr_r       <= {IW{1'b0}};
            hold_cnt_r  <= {HW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            ptr_r       <= ptr_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr
// Four arbiter configurations driven side by side: fixed priority (3),
// round robin (4), round robin with hold limit 4 (3), single requester.
// A behavioural model tracks each instance; literal expectations pin it.
// -----------------------------------------------------------------------------
module tb_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [2:0] req_fx = 3'b000;
    logic [2:0] gnt_fx;
    logic [1:0] id_fx;
    logic       v_fx;

    logic [3:0] req_rr = 4'b0000;
    logic [3:0] gnt_rr;
    logic [1:0] id_rr;
    logic       v_rr;

    logic [2:0] req_hd = 3'b000;
    logic [2:0] gnt_hd;
    logic [1:0] id_hd;
    logic       v_hd;

    logic [0:0] req_one = 1'b0;
    logic [0:0] gnt_one;
    logic [0:0] id_one;
    logic       v_one;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: granted index (-1 idle), pointer, hold count.
    int m_gnt  [4] = '{-1, -1, -1, -1};
    int m_ptr  [4] = '{0, 0, 0, 0};
    int m_hold [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    arbiter_rr #(.NREQ(3), .MODE(0), .MAX_HOLD(0)) u_fx (
        .clk(clk), .rst(rst), .req(req_fx), .gnt(gnt_fx), .gnt_id(id_fx), .gnt_valid(v_fx));
    arbiter_rr #(.NREQ(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .req(req_rr), .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(v_rr));
    arbiter_rr #(.NREQ(3), .MODE(1), .MAX_HOLD(4)) u_hd (
        .clk(clk), .rst(rst), .req(req_hd), .gnt(gnt_hd), .gnt_id(id_hd), .gnt_valid(v_hd));
    arbiter_rr #(.NREQ(1), .MODE(1), .MAX_HOLD(2)) u_one (
        .clk(clk), .rst(rst), .req(req_one), .gnt(gnt_one), .gnt_id(id_one), .gnt_valid(v_one));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the arbitration rules for instance u.
    function automatic void mstep(input int u, input int n, input int mode, input int mh,
                                  input logic [15:0] r, input logic rl);
        int  cur;
        int  excl;
        int  start;
        int  pick;
        bit  others;
        if (!rl) begin
            m_gnt[u]  = -1;
            m_ptr[u]  = 0;
            m_hold[u] = 0;
            return;
        end
        cur    = m_gnt[u];
        others = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != cur && r[i]) others = 1'b1;
        end
        if (cur >= 0 && r[cur] && !(mh > 0 && m_hold[u] == mh - 1 && others)) begin
            m_hold[u] = (m_hold[u] + 1 > mh) ? mh : m_hold[u] + 1;
        end else begin
            excl  = (cur >= 0 && r[cur]) ? cur : -1;
            start = (mode == 1) ? m_ptr[u] : 0;
            pick  = -1;
            for (int k = 0; k < n; k++) begin
                int i;
                i = (start + k) % n;
                if (pick < 0 && r[i] && i != excl) pick = i;
            end
            m_gnt[u]  = pick;
            m_hold[u] = 0;
            if (pick >= 0) m_ptr[u] = (pick + 1) % n;
        end
    endfunction

    function automatic logic [31:0] mvec(input int u);
        return (m_gnt[u] < 0) ? 32'd0 : (32'd1 << m_gnt[u]);
    endfunction

    task automatic cmp_unit(input int u, input string nm, input logic [31:0] g,
                            input logic [31:0] id, input logic v, input logic [31:0] sreq);
        check({nm, " gnt"}, g, mvec(u));
        check({nm, " gnt_id"}, id, (m_gnt[u] < 0) ? 32'd0 : 32'(m_gnt[u]));
        check({nm, " gnt_valid"}, {31'd0, v}, (m_gnt[u] < 0) ? 32'd0 : 32'd1);
        check({nm, " onehot"}, 32'($countones(g) > 1), 32'd0);
        check({nm, " stray"}, g & ~sreq, 32'd0);
    endtask

    // Model update on every edge, comparison just after it.
    always @(posedge clk) begin
        logic [31:0] s_fx, s_rr, s_hd, s_one;
        s_fx  = 32'(req_fx);
        s_rr  = 32'(req_rr);
        s_hd  = 32'(req_hd);
        s_one = 32'(req_one);
        mstep(0, 3, 0, 0, 16'(req_fx), rst);
        mstep(1, 4, 1, 0, 16'(req_rr), rst);
        mstep(2, 3, 1, 4, 16'(req_hd), rst);
        mstep(3, 1, 1, 2, 16'(req_one), rst);
        #1;
        cmp_unit(0, "fx",  32'(gnt_fx),  32'(id_fx),  v_fx,  s_fx);
        cmp_unit(1, "rr",  32'(gnt_rr),  32'(id_rr),  v_rr,  s_rr);
        cmp_unit(2, "hd",  32'(gnt_hd),  32'(id_hd),  v_hd,  s_hd);
        cmp_unit(3, "one", 32'(gnt_one), 32'(id_one), v_one, s_one);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios with literal expectations, then a random soak.
    initial begin
        logic [3:0] rr_exp [5];
        logic [1:0] rr_id  [5];
        logic [3:0] rr_req [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_req = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111};

        step(); step(); step();
        check("reset gnt_fx", 32'(gnt_fx), 32'd0);
        check("reset valid_rr", {31'd0, v_rr}, 32'd0);
        check("reset id_hd", 32'(id_hd), 32'd0);
        rst = 1'b1;

        // Fixed priority: lock on index 1, lower index does not pre-empt.
        req_fx = 3'b110;
        step();
        check("fx first grant", 32'(gnt_fx), 32'd2);
        check("fx first id", 32'(id_fx), 32'd1);
        req_fx = 3'b111;
        step();
        check("fx lock 1", 32'(gnt_fx), 32'd2);
        step();
        check("fx lock 2", 32'(gnt_fx), 32'd2);
        req_fx = 3'b101;
        step();
        check("fx release", 32'(gnt_fx), 32'd1);
        req_fx = 3'b000;
        step();
        check("fx idle valid", {31'd0, v_fx}, 32'd0);
        check("fx idle id", 32'(id_fx), 32'd0);

        // Round robin: each holder drops for one cycle after its grant.
        req_rr = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr order gnt", 32'(gnt_rr), 32'(rr_exp[i]));
            check("rr order id", 32'(id_rr), 32'(rr_id[i]));
            check("rr no bubble", {31'd0, v_rr}, 32'd1);
            req_rr = rr_req[i];
        end
        req_rr = 4'b0000;
        step();

        // Hold limit 4 with two constant requesters: alternate every 4 cycles.
        req_hd = 3'b011;
        for (int e = 0; e < 12; e++) begin
            step();
            check("hd alternate", 32'(gnt_hd), (((e / 4) % 2) == 0) ? 32'd1 : 32'd2);
        end
        req_hd = 3'b000;
        step();

        // Lone requester: never pre-empted, counter saturates.
        req_hd = 3'b100;
        for (int e = 0; e < 10; e++) begin
            step();
            check("hd lone", 32'(gnt_hd), 32'd4);
        end
        check("hd hold saturate", 32'(u_hd.hold_cnt_r), 32'd4);
        req_hd = 3'b000;
        step();

        // Reset mid-grant; pointer must restart at 0.
        req_hd = 3'b010;
        step();
        check("hd pre-reset", 32'(gnt_hd), 32'd2);
        rst    = 1'b0;
        req_hd = 3'b110;
        step();
        check("hd reset gnt", 32'(gnt_hd), 32'd0);
        check("hd reset valid", {31'd0, v_hd}, 32'd0);
        rst = 1'b1;
        step();
        check("hd after reset id", 32'(id_hd), 32'd1);

        // Single requester.
        req_one = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            check("one held", 32'(gnt_one), 32'd1);
        end

        // Random soak: model comparison and one-hot checks every edge.
        for (int c = 0; c < 300; c++) begin
            req_fx  = 3'($urandom_range(0, 7));
            req_rr  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) req_hd = 3'($urandom_range(0, 7));
            req_one = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 49) != 0);
            step();
        end
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (1..16).
REQ-002 SHALL have parameter MODE, default 1, arbitration policy: 0 = fixed priority (index 0 highest), 1 = round robin.
REQ-003 SHALL have parameter MAX_HOLD, default 0, maximum consecutive grant cycles while others wait; 0 = unlimited.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port req  input  NREQ  request vector, one bit per requester, level-held.
REQ-007 SHALL have port gnt  output  NREQ  registered one-hot grant vector (all-zero when idle).
REQ-008 SHALL have port gnt_id  output  max(1,clog2(NREQ))  index of granted requester, 0 when idle.
REQ-009 SHALL have port gnt_valid  output  1  registered OR of gnt.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (exactly one gnt bit set).
REQ-011 SHALL, in IDLE, sample req at a rising edge and, if any bit set, enter BUSY with gnt/gnt_id/gnt_valid updated at that same edge (one-cycle latency from req assertion to gnt).
REQ-012 SHALL, with MODE=0, select the lowest set index of req.
REQ-013 SHALL, with MODE=1, select the first set req index searching upward from pointer ptr with wrap-around modulo NREQ.
REQ-014 SHALL update ptr to (granted index + 1) mod NREQ at every edge where a new grant is issued; ptr unused when MODE=0.
REQ-015 SHALL hold the grant while the granted req bit remains high (packet lock), subject to REQ-018.
REQ-016 SHALL, when the granted req bit is low at an edge, re-arbitrate among remaining req bits at that same edge with no idle bubble; if none set, go to IDLE with all outputs zero.
REQ-017 SHALL maintain hold_cnt, width clog2(MAX_HOLD+1), cleared on every new grant, incremented each BUSY cycle the grant is held, saturating at MAX_HOLD.
REQ-018 SHALL, when MAX_HOLD>0, hold_cnt==MAX_HOLD-1 and at least one other req bit is set, force re-arbitration at that edge excluding the current holder (pre-emption); if no other req is set, keep the grant and saturate hold_cnt.
REQ-019 SHALL treat a pre-empted requester that keeps req high as a normal requester in subsequent arbitration.
REQ-020 SHALL never assert more than one gnt bit, and SHALL never assert gnt for a requester whose req was low at the issuing edge.
REQ-021 SHALL, for NREQ=1, grant index 0 whenever req[0] is high; pre-emption never occurs.

Reset
REQ-022 SHALL, at an edge with rst low, set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold_cnt=0, overriding any arbitration.
REQ-023 SHALL, on reset mid-grant, drop gnt at that edge and resume arbitration from ptr=0 at the first edge with rst high.

Structure
REQ-024 SHALL place MODE encodings (ARB_FIXED=0, ARB_RR=1) and a clog2 helper in shared package arb_pkg.
REQ-025 SHALL use one combinational sub-module rr_pick (inputs req vector, start index, exclude mask; outputs found flag and index) for both modes (start=0 for MODE=0).
REQ-026 SHALL register all outputs; no combinational path from req to gnt.

Verification
REQ-027 SHALL cover: NREQ=3, MODE=0, req=3'b110 then 3'b111 -> gnt=3'b010 one cycle later, held while req[1] high; req[0] rising does not pre-empt.
REQ-028 SHALL cover: NREQ=4, MODE=1, req=4'b1111 with each holder dropping req one cycle after grant -> grant order 0,1,2,3,0 with no idle cycles.
REQ-029 SHALL cover: NREQ=3, MODE=1, MAX_HOLD=4, req=3'b011 constant -> gnt 3'b001 for 4 cycles, then 3'b010 for 4 cycles, alternating.
REQ-030 SHALL cover: MAX_HOLD=4, only req[2] high for 10 cycles -> gnt=3'b100 for all 10 cycles, hold_cnt saturates at 4.
REQ-031 SHALL cover: rst driven low while gnt=3'b010 -> all outputs 0 at that edge; after release with req=3'b110, first grant is index 1 (ptr=0).
REQ-032 SHALL cover: req drops to 0 during BUSY -> gnt_valid=0 and gnt_id=0 at the next edge; random regression checks one-hot and REQ-020 every cycle.
